hazard_ctrl: RTL and testbench

Stall/flush controller for the five-stage pipeline: it drives the enable of the PC and IF2ID registers and the clear of the ID2EX register. It also sequences the multi-cycle mult/div unit, which shares HI/LO with the instructions behind it. It takes decoded register-use information from the D, E and M stages, detects data hazards that forwarding cannot resolve, and inserts bubbles. It also keeps a saturating stall counter for performance debug.

---
 rtl/hazard_ctrl.sv | 109 ++++++++++
 tb/tb_hazard_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Stall/flush controller: detects load-use and mult/div hazards in D, freezes PC/IF2ID,
// bubbles ID2EX, sequences the multi-cycle mult/div unit and counts stalled cycles.
module hazard_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    input  logic [1:0]  tuse_rs_D,
    input  logic [1:0]  tuse_rt_D,
    input  logic [4:0]  dst_E,
    input  logic [4:0]  dst_M,
    input  logic [1:0]  tnew_E,
    input  logic [1:0]  tnew_M,
    input  logic        md_use_D,
    input  logic        md_start_E,
    input  logic        md_div_E,
    output logic        pc_en,
    output logic        if2id_en,
    output logic        id2ex_clr,
    output logic        md_busy,
    output logic        md_done,
    output logic [15:0] stall_cnt
);

    typedef enum logic {
        MD_IDLE,
        MD_BUSY
    } md_state_t;

    md_state_t  md_state, md_state_nxt;
    logic [3:0] md_cnt, md_cnt_nxt;
    logic       hz_rs, hz_rt, md_hazard, stall;

    // A source of $0 never hazards, which also keeps dst=0 (no writer) from matching.
    function automatic logic reg_hz(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] de,
        input logic [1:0] te,
        input logic [4:0] dm,
        input logic [1:0] tm
    );
        return (src != 5'd0) && (((src == de) && (te > tuse)) || ((src == dm) && (tm > tuse)));
    endfunction

    always_comb begin
        hz_rs     = reg_hz(rs_D, tuse_rs_D, dst_E, tnew_E, dst_M, tnew_M);
        hz_rt     = reg_hz(rt_D, tuse_rt_D, dst_E, tnew_E, dst_M, tnew_M);
        md_hazard = md_use_D && (md_busy || md_start_E);
        stall     = hz_rs || hz_rt || md_hazard;
        pc_en     = !stall;
        if2id_en  = !stall;
        id2ex_clr = stall;
    end

    assign md_busy = (md_cnt != 4'd0);
    assign md_done = (md_cnt == 4'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            md_state <= MD_IDLE;
            md_cnt   <= 4'd0;
        end else begin
            md_state <= md_state_nxt;
            md_cnt   <= md_cnt_nxt;
        end
    end

    // A start while busy reloads the counter: the newest operation wins.
    always_comb begin
        md_state_nxt = md_state;
        md_cnt_nxt   = md_cnt;
        case (md_state)
            MD_IDLE: begin
                if (md_start_E) begin
                    md_cnt_nxt   = md_div_E ? 4'(DIV_CYC) : 4'(MULT_CYC);
                    md_state_nxt = MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (md_start_E) begin
                    md_cnt_nxt = md_div_E ? 4'(DIV_CYC) : 4'(MULT_CYC);
                end else begin
                    md_cnt_nxt = md_cnt - 4'd1;
                    if (md_cnt <= 4'd1) begin
                        md_cnt_nxt   = 4'd0;
                        md_state_nxt = MD_IDLE;
                    end
                end
            end
            default: begin
                md_state_nxt = MD_IDLE;
                md_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 16'd0;
        end else if (stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations plus a random run,
// all checked every cycle against an interval-based reference model.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  rs_D = '0, rt_D = '0, dst_E = '0, dst_M = '0;
    logic [1:0]  tuse_rs_D = 2'd3, tuse_rt_D = 2'd3, tnew_E = '0, tnew_M = '0;
    logic        md_use_D = 1'b0, md_start_E = 1'b0, md_div_E = 1'b0;
    logic        pc_en, if2id_en, id2ex_clr, md_busy, md_done;
    logic [15:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk(clk), .reset(reset),
        .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
        .dst_E(dst_E), .dst_M(dst_M), .tnew_E(tnew_E), .tnew_M(tnew_M),
        .md_use_D(md_use_D), .md_start_E(md_start_E), .md_div_E(md_div_E),
        .pc_en(pc_en), .if2id_en(if2id_en), .id2ex_clr(id2ex_clr),
        .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: the last accepted mult/div op is described by its start cycle and
    // length; busy covers the cycles (t0, t0+n], done is the last of them.
    bit mvalid = 1'b0;
    bit active = 1'b0;
    int cyc = 0;
    int t0 = 0;
    int n = 0;
    int scnt = 0;

    function automatic bit m_busy();
        return active && (cyc > t0) && (cyc <= t0 + n);
    endfunction

    function automatic bit m_done();
        return active && (cyc == t0 + n);
    endfunction

    function automatic bit m_hz(input logic [4:0] src, input logic [1:0] tuse);
        if (src == 5'd0) return 1'b0;
        if (dst_E == src && int'(tnew_E) > int'(tuse)) return 1'b1;
        if (dst_M == src && int'(tnew_M) > int'(tuse)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_stall();
        return m_hz(rs_D, tuse_rs_D) || m_hz(rt_D, tuse_rt_D) ||
               (md_use_D && (m_busy() || md_start_E));
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mvalid <= 1'b1;
            active <= 1'b0;
            scnt   <= 0;
        end else if (mvalid) begin
            if (m_stall()) scnt <= (scnt >= 65535) ? 65535 : scnt + 1;
            if (md_start_E) begin
                active <= 1'b1;
                t0     <= cyc;
                n      <= md_div_E ? 10 : 5;
            end
        end
        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mvalid) begin
            chk("pc_en", int'(pc_en), int'(!m_stall()));
            chk("if2id_en", int'(if2id_en), int'(!m_stall()));
            chk("id2ex_clr", int'(id2ex_clr), int'(m_stall()));
            chk("md_busy", int'(md_busy), int'(m_busy()));
            chk("md_done", int'(md_done), int'(m_done()));
            chk("stall_cnt", int'(stall_cnt), scnt);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        rs_D = 0; rt_D = 0; tuse_rs_D = 3; tuse_rt_D = 3;
        dst_E = 0; dst_M = 0; tnew_E = 0; tnew_M = 0;
        md_use_D = 0; md_start_E = 0; md_div_E = 0;
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_busy", int'(md_busy), 0);
        chk("rst_done", int'(md_done), 0);
        chk("rst_pc_en", int'(pc_en), 1);
        chk("rst_clr", int'(id2ex_clr), 0);
        chk("rst_cnt", int'(stall_cnt), 0);

        // Load-use: two stall cycles, then release.
        dst_E = 8; tnew_E = 2; rs_D = 8; tuse_rs_D = 0;
        #1 chk("lu_pc_en0", int'(pc_en), 0);
        chk("lu_if2id0", int'(if2id_en), 0);
        chk("lu_clr0", int'(id2ex_clr), 1);
        step();
        dst_E = 0; tnew_E = 0; dst_M = 8; tnew_M = 1;
        #1 chk("lu_pc_en1", int'(pc_en), 0);
        step();
        dst_M = 0; tnew_M = 0;
        #1 chk("lu_pc_en2", int'(pc_en), 1);
        chk("lu_cnt", int'(stall_cnt), 2);

        // $0 immunity.
        do_reset();
        rs_D = 0; dst_E = 0; tnew_E = 2; tuse_rs_D = 0;
        #1 chk("z_pc_en", int'(pc_en), 1);
        step();
        #1 chk("z_cnt", int'(stall_cnt), 0);

        // Mult with a dependent instruction waiting in D.
        do_reset();
        md_start_E = 1; md_div_E = 0; md_use_D = 1;
        #1 chk("mul_pc_en0", int'(pc_en), 0);
        chk("mul_busy0", int'(md_busy), 0);
        step();
        md_start_E = 0;
        for (int k = 1; k <= 6; k++) begin
            #1 chk("mul_busy", int'(md_busy), (k <= 5) ? 1 : 0);
            chk("mul_done", int'(md_done), (k == 5) ? 1 : 0);
            chk("mul_pc_en", int'(pc_en), (k == 6) ? 1 : 0);
            step();
        end
        md_use_D = 0;

        // Div with nothing waiting: never stalls.
        do_reset();
        md_start_E = 1; md_div_E = 1;
        #1 chk("div_pc_en0", int'(pc_en), 1);
        step();
        md_start_E = 0; md_div_E = 0;
        for (int k = 1; k <= 11; k++) begin
            #1 chk("div_busy", int'(md_busy), (k <= 10) ? 1 : 0);
            chk("div_done", int'(md_done), (k == 10) ? 1 : 0);
            chk("div_pc_en", int'(pc_en), 1);
            step();
        end

        // Reset in the middle of a div aborts it with no done pulse.
        do_reset();
        md_start_E = 1; md_div_E = 1;
        step();
        md_start_E = 0; md_div_E = 0;
        step(); step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1 chk("abort_busy", int'(md_busy), 0);
            chk("abort_done", int'(md_done), 0);
            chk("abort_cnt", int'(stall_cnt), 0);
            step();
        end

        // Random traffic with narrow register range to provoke matches.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rs_D       = 5'($urandom_range(0, 3));
            rt_D       = 5'($urandom_range(0, 3));
            dst_E      = 5'($urandom_range(0, 3));
            dst_M      = 5'($urandom_range(0, 3));
            tuse_rs_D  = 2'($urandom_range(0, 3));
            tuse_rt_D  = 2'($urandom_range(0, 3));
            tnew_E     = 2'($urandom_range(0, 3));
            tnew_M     = 2'($urandom_range(0, 3));
            md_use_D   = ($urandom_range(0, 3) == 0);
            md_start_E = ($urandom_range(0, 7) == 0);
            md_div_E   = 1'($urandom_range(0, 1));
            reset      = ($urandom_range(0, 49) == 0);
            step();
        end
        reset = 1'b0;

        // Continuous hazard saturates the counter.
        do_reset();
        rs_D = 5; dst_E = 5; tnew_E = 3; tuse_rs_D = 0;
        for (int i = 0; i < 66000; i++) step();
        chk("sat_cnt", int'(stall_cnt), 65535);
        for (int i = 0; i < 5; i++) step();
        chk("sat_hold", int'(stall_cnt), 65535);
        idle_in();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
